oven_sequencer: RTL and testbench
=================================

Name: oven_sequencer

Overview:
Master controller for the oven datapath: owns the user set-point entry, heater enable, and bake countdown. It takes over the set-temp/set-time entry, preheat gating and timer sequencing, and drives the heater, display and done indicator. It takes the board keys and switches plus the measured oven temperature from the temperature model. It outputs target temperature, remaining time, heat enable, state code and done.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s bake tick
DEFAULT_TEMP, 300, target temperature after reset/power-off (deg)
MAX_TEMP, 500, target temperature ceiling
MIN_TEMP, 65, target temperature floor
MAX_TIME, 1800, bake time ceiling (s)
PREHEAT_TOL, 5, preheat complete when cur_temp >= target_temp - PREHEAT_TOL

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pwr  in  1  oven power switch, level
key_inc  in  1  increment key, active-low, already synchronous to clk
key_dec  in  1  decrement key, active-low, already synchronous to clk
step_sel  in  6  step switches; bit0..bit4 select a step, bit5 unused
cur_temp  in  10  measured oven temperature
target_temp  out  10  current temperature set-point
remaining_time  out  13  bake seconds left (set-point while in SET_TIME)
heat_en  out  1  heater request
state  out  3  OFF=0 SET_TEMP=1 SET_TIME=2 PREHEAT=3 BAKE=4 DONE=5
done  out  1  high only in DONE

Behaviour:
- All outputs are registered. On rst (synchronous, active-high):
  - state=OFF, target_temp=DEFAULT_TEMP, remaining_time=0, heat_en=0, done=0.
  - Key history registers=1, lockout=0, tick counter=0.
- Key decode, per cycle:
  - inc_p = key_inc_q & ~key_inc & key_dec & ~lockout.
  - dec_p is symmetric.
  - confirm = ~key_inc & ~key_dec & ~lockout. Confirm sets lockout.
  - lockout clears on the first cycle both keys are high. While lockout=1, no inc_p, dec_p or confirm is generated.
  - One key falling while the other is already held low counts as confirm, not as a step.
- Step decode: exactly one of bits 0..4 must be set, otherwise the step is 0.
  - Temperature steps: 5, 10, 25, 50, 100.
  - Time steps: 5, 10, 30, 60, 300.
- Saturating arithmetic in 14-bit signed intermediate:
  - target_temp clamps to [MIN_TEMP, MAX_TEMP].
  - remaining_time clamps to [0, MAX_TIME].
- Latency: an inc_p/dec_p detected at edge N is reflected in the output after edge N.
- pwr=0 in any state: next state is OFF, with the same output values as reset. This has priority over all other transitions.
- OFF: if pwr=1, go to SET_TEMP.
- SET_TEMP:
  - inc_p/dec_p adjusts target_temp by the temperature step.
  - confirm goes to SET_TIME.
- SET_TIME:
  - inc_p/dec_p adjusts remaining_time by the time step.
  - confirm with remaining_time>0 goes to PREHEAT.
  - confirm with remaining_time=0 is consumed (lockout set) with no state change.
- PREHEAT:
  - heat_en = (cur_temp < target_temp), registered.
  - When cur_temp >= target_temp - PREHEAT_TOL (compared without underflow), go to BAKE and clear the tick counter.
  - confirm aborts to SET_TEMP with heat_en=0 and set-points kept.
- BAKE:
  - heat_en = (cur_temp < target_temp).
  - The tick counter runs 0..TICK_DIV-1; tick fires when it equals TICK_DIV-1, then wraps to 0.
  - On tick, remaining_time decrements. A tick with remaining_time=1 sets it to 0 and enters DONE on the same edge.
  - confirm aborts to SET_TEMP with heat_en=0, remaining_time kept.
  - Confirm and tick in the same cycle: abort wins and there is no decrement.
- DONE:
  - done=1, heat_en=0, remaining_time=0.
  - confirm goes to SET_TEMP with target_temp kept and done=0.
- Switch changes mid-state take effect on the next press only. cur_temp has no effect outside PREHEAT/BAKE.

Test Plan:
- Reset, then pwr=1 -> state goes 0 then 1; target_temp=300, remaining_time=0, all flags 0.
- SET_TEMP, step_sel=6'b010000, 3 inc presses -> target_temp 400, 500, 500 (saturates). Then step_sel=6'b000011, dec press -> no change (non-one-hot gives step 0).
- Hold key_inc low, then drop key_dec -> single confirm to SET_TIME, no increment. Further presses are ignored until both keys are released.
- SET_TIME confirm with time 0 -> stays in state 2. Then step_sel bit1 plus 2 inc presses -> time 20, confirm -> PREHEAT.
- PREHEAT, target 300, cur_temp ramps 290, 294, 295 -> heat_en=1 throughout; BAKE entered on the edge after cur_temp=295 is sampled.
- BAKE with TICK_DIV=4, time 2 -> remaining_time goes 1 after 4 cycles, then 0 with state=DONE after 8 cycles; done=1, heat_en=0. Dropping pwr mid-bake instead -> OFF next cycle with reset values.

Source files
------------

// File: rtl/oven_sequencer_if.sv
// Signal bundle between the oven sequencer and the board/temperature model.
// The master side is the sequencer itself.
interface oven_sequencer_if;
    logic        pwr;
    logic        key_inc;
    logic        key_dec;
    logic [5:0]  step_sel;
    logic [9:0]  cur_temp;
    logic [9:0]  target_temp;
    logic [12:0] remaining_time;
    logic        heat_en;
    logic [2:0]  state;
    logic        done;

    modport master (
        input  pwr, key_inc, key_dec, step_sel, cur_temp,
        output target_temp, remaining_time, heat_en, state, done
    );

    modport slave (
        output pwr, key_inc, key_dec, step_sel, cur_temp,
        input  target_temp, remaining_time, heat_en, state, done
    );
endinterface

// File: rtl/oven_sequencer.sv
// Oven master controller: set-point entry from two keys, preheat gating and
// a 1 s bake countdown. Every output comes straight from a register.
module oven_sequencer #(
    parameter int TICK_DIV     = 50000000,
    parameter int DEFAULT_TEMP = 300,
    parameter int MAX_TEMP     = 500,
    parameter int MIN_TEMP     = 65,
    parameter int MAX_TIME     = 1800,
    parameter int PREHEAT_TOL  = 5
) (
    input  logic               clk,
    input  logic               rst,
    oven_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        SET_TEMP = 3'd1,
        SET_TIME = 3'd2,
        PREHEAT  = 3'd3,
        BAKE     = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t            state_q, state_d;
    logic [9:0]        target_q, target_d;
    logic [12:0]       time_q, time_d;
    logic              heat_q, heat_d;
    logic              done_q, done_d;
    logic              key_inc_q, key_dec_q;
    logic              lockout_q, lockout_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;

    logic              inc_p, dec_p, confirm, tick, preheat_ok;
    logic signed [13:0] temp_step, time_step;
    logic signed [13:0] temp_sum, time_sum;
    logic [9:0]        temp_sat;
    logic [12:0]       time_sat;

    // A key falling while the other is still held is a confirm, never a step.
    assign inc_p   = key_inc_q & ~bus.key_inc & bus.key_dec & ~lockout_q;
    assign dec_p   = key_dec_q & ~bus.key_dec & bus.key_inc & ~lockout_q;
    assign confirm = ~bus.key_inc & ~bus.key_dec & ~lockout_q;
    assign tick    = (state_q == BAKE) && (tick_cnt_q == TICK_LAST);
    assign preheat_ok = ({1'b0, bus.cur_temp} + 11'(PREHEAT_TOL)) >= {1'b0, target_q};

    always_comb begin
        temp_step = '0;
        time_step = '0;
        casez (bus.step_sel)
            6'b?00001: begin temp_step = 14'sd5;   time_step = 14'sd5;   end
            6'b?00010: begin temp_step = 14'sd10;  time_step = 14'sd10;  end
            6'b?00100: begin temp_step = 14'sd25;  time_step = 14'sd30;  end
            6'b?01000: begin temp_step = 14'sd50;  time_step = 14'sd60;  end
            6'b?10000: begin temp_step = 14'sd100; time_step = 14'sd300; end
            default:   begin temp_step = '0;       time_step = '0;       end
        endcase
    end

    always_comb begin
        temp_sum = $signed({4'b0, target_q});
        time_sum = $signed({1'b0, time_q});
        if (inc_p) begin
            temp_sum = temp_sum + temp_step;
            time_sum = time_sum + time_step;
        end else if (dec_p) begin
            temp_sum = temp_sum - temp_step;
            time_sum = time_sum - time_step;
        end

        if (temp_sum > MAX_TEMP)
            temp_sat = 10'(MAX_TEMP);
        else if (temp_sum < MIN_TEMP)
            temp_sat = 10'(MIN_TEMP);
        else
            temp_sat = temp_sum[9:0];

        if (time_sum > MAX_TIME)
            time_sat = 13'(MAX_TIME);
        else if (time_sum < 0)
            time_sat = '0;
        else
            time_sat = time_sum[12:0];
    end

    // Next-state and next-output logic; power-off overrides everything.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        time_d     = time_q;
        heat_d     = 1'b0;
        done_d     = 1'b0;
        tick_cnt_d = '0;
        lockout_d  = lockout_q;

        if (confirm)
            lockout_d = 1'b1;
        else if (bus.key_inc && bus.key_dec)
            lockout_d = 1'b0;

        if (!bus.pwr) begin
            state_d  = OFF;
            target_d = 10'(DEFAULT_TEMP);
            time_d   = '0;
        end else begin
            case (state_q)
                OFF: state_d = SET_TEMP;
                SET_TEMP: begin
                    if (confirm)
                        state_d = SET_TIME;
                    else if (inc_p || dec_p)
                        target_d = temp_sat;
                end
                SET_TIME: begin
                    if (confirm) begin
                        if (time_q != '0)
                            state_d = PREHEAT;
                    end else if (inc_p || dec_p) begin
                        time_d = time_sat;
                    end
                end
                PREHEAT: begin
                    if (confirm) begin
                        state_d = SET_TEMP;
                    end else begin
                        heat_d = bus.cur_temp < target_q;
                        if (preheat_ok)
                            state_d = BAKE;
                    end
                end
                BAKE: begin
                    if (confirm) begin
                        state_d = SET_TEMP;
                    end else begin
                        heat_d = bus.cur_temp < target_q;
                        if (!tick) begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end else if (time_q <= 13'd1) begin
                            time_d  = '0;
                            state_d = DONE;
                            heat_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            time_d = time_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    time_d = '0;
                    if (confirm)
                        state_d = SET_TEMP;
                    else
                        done_d = 1'b1;
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            target_q   <= 10'(DEFAULT_TEMP);
            time_q     <= '0;
            heat_q     <= 1'b0;
            done_q     <= 1'b0;
            key_inc_q  <= 1'b1;
            key_dec_q  <= 1'b1;
            lockout_q  <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            time_q     <= time_d;
            heat_q     <= heat_d;
            done_q     <= done_d;
            key_inc_q  <= bus.key_inc;
            key_dec_q  <= bus.key_dec;
            lockout_q  <= lockout_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.target_temp    = target_q;
    assign bus.remaining_time = time_q;
    assign bus.heat_en        = heat_q;
    assign bus.state          = state_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_oven_sequencer.sv
// Directed bench for oven_sequencer: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_oven_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       pwr_v  = 1'b0;
    logic [5:0] sel_v  = 6'b0;
    logic [9:0] temp_v = 10'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [9:0]  tt;
        logic [12:0] rt;
        logic        he;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];

    oven_sequencer_if bus();

    oven_sequencer #(.TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ki, input logic kd);
        bus.key_inc  = ki;
        bus.key_dec  = kd;
        bus.pwr      = pwr_v;
        bus.step_sel = sel_v;
        bus.cur_temp = temp_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] st, input logic [9:0] tt,
                               input logic [12:0] rt, input logic he, input logic dn);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.tt   = tt;
        e.rt   = rt;
        e.he   = he;
        e.dn   = dn;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (bus.state !== e.st || bus.target_temp !== e.tt || bus.remaining_time !== e.rt ||
                bus.heat_en !== e.he || bus.done !== e.dn) begin
                bad++;
                $display("[TB] FAIL %s: got state=%0d temp=%0d time=%0d heat=%b done=%b, want state=%0d temp=%0d time=%0d heat=%b done=%b",
                         e.name, bus.state, bus.target_temp, bus.remaining_time, bus.heat_en, bus.done,
                         e.st, e.tt, e.rt, e.he, e.dn);
            end
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset", 3'd0, 10'd300, 13'd0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("off_idle", 3'd0, 10'd300, 13'd0, 1'b0, 1'b0);
        pwr_v = 1'b1;
        applyStimulus(1'b1, 1'b1);
        checkOutput("pwr_on", 3'd1, 10'd300, 13'd0, 1'b0, 1'b0);

        sel_v = 6'b010000;
        applyStimulus(1'b0, 1'b1);
        checkOutput("inc100_a", 3'd1, 10'd400, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("inc100_b", 3'd1, 10'd500, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("inc_sat", 3'd1, 10'd500, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        sel_v = 6'b000011;
        applyStimulus(1'b1, 1'b0);
        checkOutput("dec_nonhot", 3'd1, 10'd500, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        sel_v = 6'b010000;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("dec100", 3'd1, 10'd300, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        // Hold inc, then drop dec: the second fall must be a confirm only.
        sel_v = 6'b000000;
        applyStimulus(1'b0, 1'b1);
        checkOutput("inc_hold", 3'd1, 10'd300, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("confirm_temp", 3'd2, 10'd300, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0);
        checkOutput("time0_confirm", 3'd2, 10'd300, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        sel_v = 6'b000001;
        applyStimulus(1'b1, 1'b0);
        checkOutput("time_floor", 3'd2, 10'd300, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        sel_v = 6'b000010;
        applyStimulus(1'b0, 1'b1);
        checkOutput("time10", 3'd2, 10'd300, 13'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("time20", 3'd2, 10'd300, 13'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        temp_v = 10'd100;
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_preheat", 3'd3, 10'd300, 13'd20, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lock_hold", 3'd3, 10'd300, 13'd20, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("lock_block", 3'd3, 10'd300, 13'd20, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("lock_clear", 3'd3, 10'd300, 13'd20, 1'b1, 1'b0);

        temp_v = 10'd290;
        applyStimulus(1'b1, 1'b1);
        checkOutput("ramp290", 3'd3, 10'd300, 13'd20, 1'b1, 1'b0);
        temp_v = 10'd294;
        applyStimulus(1'b1, 1'b1);
        checkOutput("ramp294", 3'd3, 10'd300, 13'd20, 1'b1, 1'b0);
        temp_v = 10'd295;
        applyStimulus(1'b1, 1'b1);
        checkOutput("preheat_done", 3'd4, 10'd300, 13'd20, 1'b1, 1'b0);

        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("bake_no_tick", 3'd4, 10'd300, 13'd20, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("first_tick", 3'd4, 10'd300, 13'd19, 1'b1, 1'b0);
        temp_v = 10'd310;
        applyStimulus(1'b1, 1'b1);
        checkOutput("heat_off_hot", 3'd4, 10'd300, 13'd19, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (68) applyStimulus(1'b1, 1'b1);
        checkOutput("time1", 3'd4, 10'd300, 13'd1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_done", 3'd4, 10'd300, 13'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("bake_done", 3'd5, 10'd300, 13'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("done_hold", 3'd5, 10'd300, 13'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("done_confirm", 3'd1, 10'd300, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        sel_v = 6'b000100;
        applyStimulus(1'b0, 1'b1);
        checkOutput("inc25", 3'd1, 10'd325, 13'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        sel_v = 6'b000010;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        temp_v = 10'd322;
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_preheat2", 3'd3, 10'd325, 13'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rebake", 3'd4, 10'd325, 13'd10, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_abort", 3'd4, 10'd325, 13'd10, 1'b1, 1'b0);
        // Confirm lands on the tick cycle: abort wins, no decrement.
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_tick", 3'd1, 10'd325, 13'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0);
        checkOutput("re_set_time", 3'd2, 10'd325, 13'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("bake_again", 3'd4, 10'd325, 13'd10, 1'b1, 1'b0);
        pwr_v = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("pwr_off", 3'd0, 10'd300, 13'd0, 1'b0, 1'b0);
        pwr_v = 1'b1;
        applyStimulus(1'b1, 1'b1);
        checkOutput("pwr_back", 3'd1, 10'd300, 13'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending checks, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
